// File: rtl/data_ram_pipe.sv
// -----------------------------------------------------------------------------
// data_ram_pipe
//
// Single-port data memory for the processor datapath. Width and depth are
// parameters. Reads are registered and pipelined with a latency of READ_LAT
// cycles and full throughput. Requests use a ready/valid handshake. An optional
// sequencer zeroes every word after reset. A read and a write requested on the
// same accepted edge are flagged as a collision.
//
// Parameters
//   DATA_W         word width in bits
//   ADDR_W         address width; DEPTH = 2**ADDR_W words
//   READ_LAT       read latency in cycles, legal range 1..4
//   CLEAR_ON_RESET 1: zero the whole memory after every reset
//   INIT_FILE      binary image that the implementation flow attaches to the
//                  array as its power-up content; a post-reset clear replaces it
//
// Ports
//   CLK        clock; all state updates on posedge
//   RST_N      synchronous active-low reset
//   MemRead    read request
//   MemWrite   write request
//   Address    word address
//   WriteData  write data
//   MemOut     read data; holds its value between reads
//   MemValid   MemOut carries new read data this cycle
//   MemReady   requests are accepted this cycle
//   ErrCollide one-cycle pulse after an accepted read+write collision
// -----------------------------------------------------------------------------
module data_ram_pipe #(
    parameter int    DATA_W         = 8,
    parameter int    ADDR_W         = 8,
    parameter int    READ_LAT       = 1,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = "dataram_init.list"
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] MemOut,
    output logic              MemValid,
    output logic              MemReady,
    output logic              ErrCollide
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_CLEAR       = 1'b0;
    localparam logic [0:0] ST_RUN         = 1'b1;
    localparam logic [0:0] ST_AFTER_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_out;
    logic              r_valid;
    logic              r_collide;

    logic              w_ready;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_collide;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_last_vld;
    logic [DATA_W-1:0] w_last_dat;

    // Ready is gated by RST_N so that it is low for the whole reset window,
    // including the cycle in which reset is first asserted.
    assign w_ready   = (r_state == ST_RUN) && RST_N;
    assign w_rd_word = r_mem[Address];

    // Request acceptance: on a collision the write wins and the read is dropped.
    always_comb begin
        w_wr_acc  = 1'b0;
        w_rd_acc  = 1'b0;
        w_collide = 1'b0;
        if (w_ready) begin
            w_wr_acc  = MemWrite;
            w_rd_acc  = MemRead && !MemWrite;
            w_collide = MemRead && MemWrite;
        end else begin
            w_wr_acc  = 1'b0;
            w_rd_acc  = 1'b0;
            w_collide = 1'b0;
        end
    end

    // CLEAR/RUN sequencer and clear address counter.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= ST_AFTER_RESET;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + ADDR_ONE;
                    if (r_clr_cnt == ADDR_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_RUN: begin
                    r_state   <= ST_RUN;
                    r_clr_cnt <= r_clr_cnt;
                end
                default: begin
                    r_state   <= ST_AFTER_RESET;
                    r_clr_cnt <= '0;
                end
            endcase
        end
    end

    // Memory array: clear writes during CLEAR, accepted writes during RUN.
    // Reset itself never touches the contents.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr_acc) begin
                r_mem[Address] <= WriteData;
            end
        end
    end

    // The array read at the accepting edge is the first of READ_LAT register
    // stages; the output register below is always the last one.
    if (READ_LAT <= 1) begin : g_lat1
        assign w_last_vld = w_rd_acc;
        assign w_last_dat = w_rd_word;
    end else begin : g_latn
        logic [READ_LAT-2:0] r_pipe_vld;
        logic [DATA_W-1:0]   r_pipe_dat [READ_LAT-1];

        // Intermediate read stages; valid bits are flushed by reset.
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                r_pipe_vld <= '0;
                for (int k = 0; k < READ_LAT - 1; k++) begin
                    r_pipe_dat[k] <= '0;
                end
            end else begin
                r_pipe_vld[0] <= w_rd_acc;
                r_pipe_dat[0] <= w_rd_word;
                for (int k = 1; k < READ_LAT - 1; k++) begin
                    r_pipe_vld[k] <= r_pipe_vld[k-1];
                    r_pipe_dat[k] <= r_pipe_dat[k-1];
                end
            end
        end

        assign w_last_vld = r_pipe_vld[READ_LAT-2];
        assign w_last_dat = r_pipe_dat[READ_LAT-2];
    end

    // Output registers: MemOut only loads on a completing read so it holds
    // between reads; the collision flag is a one-cycle pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_collide <= 1'b0;
        end else begin
            r_valid   <= w_last_vld;
            r_collide <= w_collide;
            if (w_last_vld) begin
                r_out <= w_last_dat;
            end else begin
                r_out <= r_out;
            end
        end
    end

    assign MemOut     = r_out;
    assign MemValid   = r_valid;
    assign MemReady   = w_ready;
    assign ErrCollide = r_collide;

endmodule

// File: doc/data_ram_pipe.md
# data_ram_pipe

Parametrised single-port data memory for the processor datapath. Replaces the fixed 8-bit/256-entry data RAM with configurable width and depth and a registered, pipelined read of configurable latency. Adds a ready/valid handshake, an optional post-reset clear sequencer, and read/write collision detection. It sits between the load/store stage and the memory-mapped data space.

## Interface
Parameters:
- DATA_W, default 8: word width in bits.
- ADDR_W, default 8: address width; DEPTH = 2**ADDR_W words.
- READ_LAT, default 1: read latency in cycles, legal range 1..4.
- CLEAR_ON_RESET, default 1: when 1, memory is zeroed after every reset.
- INIT_FILE, default "dataram_init.list": binary image loaded at time zero.

Ports:
- CLK  in  1  clock; all logic updates on posedge.
- RST_N  in  1  reset, synchronous, active-low.
- MemRead  in  1  read request.
- MemWrite  in  1  write request.
- Address  in  ADDR_W  word address.
- WriteData  in  DATA_W  write data.
- MemOut  out  DATA_W  read data; holds its value between reads.
- MemValid  out  1  MemOut carries new read data this cycle.
- MemReady  out  1  requests are accepted this cycle.
- ErrCollide  out  1  one-cycle pulse when MemRead and MemWrite are accepted together.

## Operation
- States: CLEAR and RUN.
- Reset (RST_N=0 at a posedge):
  - State goes to CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - Clear counter = 0; read pipeline valid bits = 0.
  - MemOut=0, MemValid=0, ErrCollide=0.
  - MemReady=0 throughout reset.
- CLEAR:
  - Writes 0 to word[counter] each cycle, then increments the counter.
  - After writing word DEPTH-1, moves to RUN; the clear takes exactly DEPTH cycles.
  - MemReady=0 in CLEAR. Requests are ignored and dropped; requesters must wait for MemReady.
- RUN: MemReady=1. A request is accepted on any posedge where MemReady=1 and MemRead or MemWrite is high.
- Write: word[Address] <= WriteData at the accepting edge.
- Read:
  - Word[Address] is sampled at the accepting edge, reflecting every write accepted at earlier edges.
  - The result passes through READ_LAT-1 further register stages.
  - Back-to-back reads are accepted every cycle (full throughput).
- Ordering:
  - A write accepted at the edge after a read does not affect that read.
  - A read after a write to the same address returns the new data.
- Collision (MemRead=1 and MemWrite=1 at an accepted edge):
  - The write is performed and the read is dropped; no MemValid results from it.
  - ErrCollide=1 for the following cycle.
- Address is always in range; there is no wrap logic beyond ADDR_W truncation.
- Reset mid-operation (during CLEAR or with reads in flight):
  - In-flight reads are discarded and never produce MemValid.
  - The clear restarts from word 0.
  - Memory is not otherwise altered by reset.
- INIT_FILE is loaded once at time zero. With CLEAR_ON_RESET=1 the clear overwrites it.

## Timing
- After RST_N rises, MemReady=1 on:
  - cycle DEPTH+1 if CLEAR_ON_RESET=1;
  - cycle 1 if CLEAR_ON_RESET=0.
- Read accepted at edge t: MemValid=1 and MemOut=data during the cycle after edge t+READ_LAT-1, i.e. READ_LAT cycles after the request.
- MemValid is high for exactly one cycle per accepted read.
- Write accepted at edge t is visible to a read accepted at edge t+1.
- ErrCollide goes high the cycle after the colliding edge, for one cycle.

## Test plan
- Reset, CLEAR_ON_RESET=1, DEPTH=256: MemReady stays 0 for 256 cycles, then goes 1. Reads of addresses 0x00, 0x7F and 0xFF each return 0 with MemValid.
- READ_LAT=3: write 0xA5 to 0x10, then read 0x10 on the next cycle. MemValid is asserted 3 cycles after the read request, with MemOut=0xA5.
- Streaming: write 0x01..0x08 to 0x20..0x27, then 8 consecutive reads. Eight consecutive MemValid pulses return 0x01..0x08 in order with no gaps.
- Read then write: read 0x30 (holding 0x11), and write 0x22 to 0x30 on the next cycle. The read returns 0x11; a later read returns 0x22.
- Collision: MemRead=MemWrite=1 at 0x40 with WriteData=0x5A. ErrCollide pulses once and no MemValid is produced; a later read returns 0x5A.
- Mid-operation reset: assert RST_N=0 with 2 reads in flight and 100 cycles into the clear. No MemValid appears, MemOut=0, and the full clear restarts (MemReady=0 for 256 cycles).
